// File: rtl/pdm_ser_pkg.sv
// Shared types and constants for the PDM/serial audio output stage.
package pdm_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pdm_state_e;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_CLK_DIV    = 50;
    localparam int unsigned UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/pdm_clk_div.sv
// Bit-clock divider: toggles pdm_clk_o every CLK_DIV system clocks and flags
// the last system-clock cycle before each falling edge.
module pdm_clk_div
    import pdm_ser_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic enable_i,
    output logic pdm_clk_o,
    output logic fall_tick_c
);

    localparam int unsigned      CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_max_c;

    assign at_max_c    = (cnt == CNT_MAX);
    assign fall_tick_c = enable_i && at_max_c && pdm_clk_o;

    // Half-period counter; disable parks the bit clock low.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt       <= '0;
            pdm_clk_o <= 1'b0;
        end else if (!enable_i) begin
            cnt       <= '0;
            pdm_clk_o <= 1'b0;
        end else if (at_max_c) begin
            cnt       <= '0;
            pdm_clk_o <= ~pdm_clk_o;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pdm_stream_serializer.sv
// Parallel-to-serial PDM audio output with a one-word holding buffer.
// Build option: define PDM_SER_UNDERRUN_CNT_EN to add the saturating underrun_cnt_o.
module pdm_stream_serializer
    import pdm_ser_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              pdm_clk_o,
    output logic              pdm_audio_o,
    output logic              pdm_sdaudio_o,
    output logic              done_o,
    output logic              underrun_o
`ifdef PDM_SER_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
`endif
);

    localparam int unsigned      BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    pdm_state_e        state, state_nxt;
    logic              fall_tick_c;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] shift_q;
    logic [BIT_W-1:0]  bit_cnt;

    logic              hs_c, last_bit_c, need_word_c, load_buf_c, load_byp_c;
    logic              shift_c, done_c, underrun_c;
    logic [DATA_W-1:0] load_word_c, shift_nxt_c;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    pdm_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .enable_i    (enable_i),
        .pdm_clk_o   (pdm_clk_o),
        .fall_tick_c (fall_tick_c)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (load_buf_c || load_byp_c) state_nxt = SHIFT;
                SHIFT:   if (underrun_c)               state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A word is needed at the fall tick that ends idle or the last bit; a
    // handshake landing on that tick goes straight to the shifter.
    always_comb begin
        hs_c        = valid_i && ready_o && enable_i;
        last_bit_c  = (state == SHIFT) && (bit_cnt == BIT_LAST);
        need_word_c = fall_tick_c && ((state == IDLE) || last_bit_c);
        load_buf_c  = need_word_c && !ready_o;
        load_byp_c  = need_word_c && hs_c;
        shift_c     = fall_tick_c && (state == SHIFT) && !last_bit_c;
        done_c      = fall_tick_c && last_bit_c;
        underrun_c  = done_c && !load_buf_c && !load_byp_c;
        load_word_c = load_buf_c ? buf_q : data_i;
        shift_nxt_c = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0}
                                : {1'b0, shift_q[DATA_W-1:1]};
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_o     <= 1'b1;
            buf_q       <= '0;
            shift_q     <= '0;
            bit_cnt     <= '0;
            pdm_audio_o <= 1'b0;
            done_o      <= 1'b0;
            underrun_o  <= 1'b0;
        end else if (!enable_i) begin
            ready_o     <= 1'b1;
            buf_q       <= '0;
            shift_q     <= '0;
            bit_cnt     <= '0;
            pdm_audio_o <= 1'b0;
            done_o      <= 1'b0;
            underrun_o  <= 1'b0;
        end else begin
            done_o     <= done_c;
            underrun_o <= underrun_c;
            if (load_buf_c || load_byp_c) begin
                shift_q     <= load_word_c;
                pdm_audio_o <= first_bit(load_word_c);
                bit_cnt     <= '0;
            end else if (shift_c) begin
                shift_q     <= shift_nxt_c;
                pdm_audio_o <= first_bit(shift_nxt_c);
                bit_cnt     <= bit_cnt + 1'b1;
            end else if (underrun_c) begin
                pdm_audio_o <= 1'b0;
            end
            if (load_buf_c) begin
                ready_o <= 1'b1;
            end else if (hs_c && !load_byp_c) begin
                ready_o <= 1'b0;
                buf_q   <= data_i;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) pdm_sdaudio_o <= 1'b0;
        else            pdm_sdaudio_o <= enable_i;
    end

`ifdef PDM_SER_UNDERRUN_CNT_EN
    // Survives soft clear; only the hard reset zeroes it.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            underrun_cnt_o <= '0;
        else if (underrun_o && (underrun_cnt_o != '1))
            underrun_cnt_o <= underrun_cnt_o + 1'b1;
    end
`endif

endmodule

// File: doc/pdm_stream_serializer.md
# pdm_stream_serializer

Parametrised PDM/serial audio output stage that accepts parallel sample words over a valid/ready handshake and shifts them out MSB- or LSB-first on a bit clock derived from the system clock. It sits between the sample source (tone/sample generator or FIFO) and the board audio pins. It generates the bit clock, the audio data line and the amplifier shutdown line. A one-word holding buffer gives gap-free back-to-back streaming, and per-word done/underrun pulses are reported.

## Interface
Parameters:
- DATA_W, 16, sample word width in bits; legal range ≥2.
- CLK_DIV, 50, system clocks per bit-clock half-period; legal range ≥2.
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first, 0 = bit 0 is sent first.

Ports:
- clock_i  in  1  system clock; all logic runs on its rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  run enable; low acts as a synchronous soft clear.
- data_i  in  DATA_W  sample word.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  holding buffer is empty; a word transfers when valid_i && ready_o.
- pdm_clk_o  out  1  bit clock, registered.
- pdm_audio_o  out  1  serial data line, registered.
- pdm_sdaudio_o  out  1  amplifier enable, registered copy of enable_i.
- done_o  out  1  one-clock pulse when a word's last bit period ends.
- underrun_o  out  1  one-clock pulse when a word ends with no successor available.

## Operation
- **Reset values:** ready_o=1; pdm_clk_o, pdm_audio_o, pdm_sdaudio_o, done_o and underrun_o are 0. Divider is 0, FSM is IDLE, buffer is empty.
- **Divider:**
  - While enable_i=1, the counter steps 0..CLK_DIV-1.
  - When it reaches CLK_DIV-1, the counter wraps to 0 and pdm_clk_o toggles.
  - A fall tick is the cycle where the count is CLK_DIV-1 and pdm_clk_o=1.
- **Holding buffer:** a handshake loads the buffer and sets ready_o=0 on the next edge.
- **FSM IDLE:**
  - The divider runs and pdm_audio_o=0.
  - On a fall tick, if the buffer is full, the buffer moves into the shift register, the first bit drives pdm_audio_o, the bit counter is set to 0, the buffer empties and the FSM goes to SHIFT.
- **FSM SHIFT, fall tick with bit counter < DATA_W-1:** shift, drive the next bit, increment the bit counter.
- **FSM SHIFT, fall tick with bit counter = DATA_W-1:** done_o pulses. Then:
  - Buffer full: load the next word and drive its first bit; the FSM stays in SHIFT with no gap.
  - Buffer empty: underrun_o pulses in the same cycle as done_o, pdm_audio_o goes to 0 and the FSM goes to IDLE.
- **Handshake on a fall tick:** if a handshake occurs on the same clock as a fall tick that needs a word, the word bypasses the buffer into the shift register. No underrun is flagged and ready_o stays 1.
- **enable_i=0:** on the next edge the divider, pdm_clk_o, pdm_audio_o, bit counter, buffer (ready_o=1), done_o and underrun_o all clear and the FSM goes to IDLE. Handshakes are ignored while enable_i=0. pdm_sdaudio_o follows enable_i with one clock of latency.
- **Widths:** the divider counter is $clog2(CLK_DIV) bits and the bit counter is $clog2(DATA_W) bits. Neither counter passes its terminal value.

## Timing
- Each bit is held for 2·CLK_DIV clocks; one word takes 2·CLK_DIV·DATA_W clocks.
- pdm_audio_o changes on the same edge that pdm_clk_o falls, so the data line is stable at every bit-clock rise.
- Latency from handshake to first bit (from IDLE) is at most 2·CLK_DIV clocks: the next fall tick.
- done_o and underrun_o are single-cycle pulses and are never asserted for two consecutive cycles.
- Reset asynchronously clears state at any point, including mid-word; the output reset values hold until reset_n_i deasserts.

## Configuration
- Macro PDM_SER_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt_o (16 bits). It increments on each underrun_o pulse, saturates at 16'hFFFF, and is cleared only by reset_n_i (not by enable_i).
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package pdm_ser_pkg contains:
  - the FSM state enum typedef (IDLE, SHIFT);
  - the default DATA_W and CLK_DIV constants;
  - the underrun counter width constant.
- Sub-module pdm_clk_div contains the divider. It outputs pdm_clk_o and the fall-tick strobe and is parametrised by CLK_DIV.

## Test plan
Bench uses DATA_W=16, CLK_DIV=4.
- Reset with all inputs active → all outputs 0 except ready_o=1. Reset deassert with enable_i=1 → pdm_clk_o period of 8 clocks.
- One word 16'hA5C3 → serial bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, each held 8 clocks. After 128 clocks, done_o and underrun_o pulse together and pdm_audio_o returns to 0.
- Words 16'hFFFF then 16'h0001 back-to-back:
  - ready_o stays low from the second handshake until the first word ends.
  - 32 contiguous bit periods are sent with no gap.
  - Two done_o pulses; underrun_o pulses only after the second word.
- Handshake on the exact fall-tick cycle of the last bit → bypass load, no underrun, ready_o stays 1.
- enable_i dropped during bit 7 → next edge: pdm_clk_o=0, pdm_audio_o=0, ready_o=1, no done_o; pdm_sdaudio_o falls one clock after enable_i. Repeat with reset_n_i asserted mid-word → immediate clear.
- MSB_FIRST=0 with 16'h0001 → first bit 1 then fifteen 0s. With PDM_SER_UNDERRUN_CNT_EN defined, three isolated words → underrun_cnt_o=3.
